// File: rtl/gate_fault_pkg.sv
// Shared types and helpers for the fault-injection gate family.
package gate_fault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_COOLDOWN = 2'd2
  } gate_state_e;

  localparam logic [1:0] MODE_PROP   = 2'b00;
  localparam logic [1:0] MODE_THRESH = 2'b01;
  localparam logic [1:0] MODE_ANY    = 2'b10;
  localparam logic [1:0] MODE_ALL    = 2'b11;

  // Bits needed to hold a popcount of n inputs (0..n).
  function automatic int popcount_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gate_lfsr.sv
// Free-running Fibonacci-style LFSR, shifting left with XOR feedback of tapped bits.
module gate_lfsr #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   TAPS  = 16'hD008,
  parameter logic [WIDTH-1:0]   SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;
  logic             w_fb;

  assign w_fb  = ^(r_value & TAPS);
  assign value = r_value;

  // Load seed on reset, otherwise advance one step every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_value <= SEED;
    end else begin
      r_value <= {r_value[WIDTH-2:0], w_fb};
    end
  end

endmodule

// File: rtl/gate_multi_fault_fsm.sv
// Multi-input fault gate: decides per cycle whether a fault fires and holds it.
//
// state    | meaning
// IDLE     | waiting for a trigger
// ACTIVE   | out asserted; hold counter running (frozen while sticky)
// COOLDOWN | triggers ignored until cooldown counter expires
module gate_multi_fault_fsm
  import gate_fault_pkg::*;
#(
  parameter int                      INPUT_COUNT     = 4,
  parameter int                      LFSR_WIDTH      = 16,
  parameter logic [LFSR_WIDTH-1:0]   LFSR_TAPS       = 16'hD008,
  parameter logic [LFSR_WIDTH-1:0]   RAND_SEED       = 16'hACE1,
  parameter int                      THRESHOLD       = 2,
  parameter int                      HOLD_CYCLES     = 4,
  parameter int                      COOLDOWN_CYCLES = 2,
  parameter int                      CNT_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   logic_reset,
  input  logic [1:0]             mode,
  input  logic                   sticky,
  input  logic [INPUT_COUNT-1:0] in,
  input  logic                   fault_in,
  output logic                   out,
  output logic [1:0]             state_o,
  output logic [CNT_WIDTH-1:0]   fault_count
);

  localparam int OW = popcount_width(INPUT_COUNT);
  localparam int PW = LFSR_WIDTH + OW;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int CW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);

  // Per-input slice of the LFSR range; the product with popcount is kept wide.
  localparam longint unsigned STEP64 =
    ((64'd1 << LFSR_WIDTH) - 64'd1) / 64'(INPUT_COUNT);
  localparam logic [LFSR_WIDTH-1:0] STEP      = LFSR_WIDTH'(STEP64);
  localparam logic [HW-1:0]         HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]         CD_LOAD   =
    CW'((COOLDOWN_CYCLES > 0) ? (COOLDOWN_CYCLES - 1) : 0);

  logic [LFSR_WIDTH-1:0] w_lfsr;
  logic [OW-1:0]         w_ones;
  logic [PW-1:0]         w_prod;
  logic                  w_hit;
  logic                  w_trig;

  gate_state_e           r_state, w_next_state;
  logic [HW-1:0]         r_hold, w_next_hold;
  logic [CW-1:0]         r_cd, w_next_cd;
  logic                  w_fire;
  logic                  r_out;
  logic [CNT_WIDTH-1:0]  r_count;

  gate_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (RAND_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (w_lfsr)
  );

  // Count how many monitored inputs are high.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      w_ones = w_ones + OW'(in[i]);
    end
  end

  assign w_prod = PW'(w_ones) * PW'(STEP);

  // Mode-dependent trigger decision.
  always_comb begin
    w_hit = 1'b0;
    case (mode)
      MODE_PROP:   w_hit = (PW'(w_lfsr) < w_prod);
      MODE_THRESH: w_hit = (w_ones >= OW'(THRESHOLD));
      MODE_ANY:    w_hit = (w_ones != '0);
      MODE_ALL:    w_hit = (w_ones == OW'(INPUT_COUNT));
      default:     w_hit = 1'b0;
    endcase
  end

  assign w_trig = fault_in & w_hit;

  // Next-state and counter logic; functional clear overrides any trigger.
  always_comb begin
    w_next_state = r_state;
    w_next_hold  = r_hold;
    w_next_cd    = r_cd;
    w_fire       = 1'b0;
    if (logic_reset) begin
      w_next_state = ST_IDLE;
      w_next_hold  = '0;
      w_next_cd    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            w_next_state = ST_ACTIVE;
            w_next_hold  = HOLD_LOAD;
            w_fire       = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!sticky) begin
            if (w_trig) begin
              w_next_hold = HOLD_LOAD;
            end else if (r_hold == '0) begin
              if (COOLDOWN_CYCLES == 0) begin
                w_next_state = ST_IDLE;
              end else begin
                w_next_state = ST_COOLDOWN;
                w_next_cd    = CD_LOAD;
              end
            end else begin
              w_next_hold = r_hold - 1'b1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (r_cd == '0) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_cd = r_cd - 1'b1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_hold  = '0;
          w_next_cd    = '0;
        end
      endcase
    end
  end

  // State, counters, registered output and saturating fire counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_cd    <= '0;
      r_out   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_hold  <= w_next_hold;
      r_cd    <= w_next_cd;
      r_out   <= (w_next_state == ST_ACTIVE);
      if (w_fire && !(&r_count)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign out         = r_out;
  assign state_o     = r_state;
  assign fault_count = r_count;

endmodule

// File: tb/tb_gate_multi_fault_fsm.sv
// Directed bench for gate_multi_fault_fsm: default instance plus a short-hold,
// no-cooldown, 2-bit-counter instance sharing the same stimulus.
module tb_gate_multi_fault_fsm;

  logic       clk;
  logic       reset_n;
  logic       logic_reset;
  logic [1:0] mode;
  logic       sticky;
  logic [3:0] in_v;
  logic       fault_in;

  logic       out1;
  logic [1:0] st1;
  logic [7:0] cnt1;
  logic       out2;
  logic [1:0] st2;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr;

  gate_multi_fault_fsm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .logic_reset (logic_reset),
    .mode        (mode),
    .sticky      (sticky),
    .in          (in_v),
    .fault_in    (fault_in),
    .out         (out1),
    .state_o     (st1),
    .fault_count (cnt1)
  );

  gate_multi_fault_fsm #(
    .HOLD_CYCLES     (1),
    .COOLDOWN_CYCLES (0),
    .CNT_WIDTH       (2)
  ) dut2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .logic_reset (logic_reset),
    .mode        (mode),
    .sticky      (sticky),
    .in          (in_v),
    .fault_in    (fault_in),
    .out         (out2),
    .state_o     (st2),
    .fault_count (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR written from the feedback formula.
  always @(posedge clk) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hD008)};
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; logic_reset = 1'b0; mode = 2'b11; sticky = 1'b0;
    in_v = 4'hF; fault_in = 1'b1;
    @(negedge clk);
    tick(); tick();
    checks++; if (out1 !== 1'b0)  begin errors++; $display("FAIL reset_out got=%b exp=0", out1); end
    checks++; if (st1 !== 2'd0)   begin errors++; $display("FAIL reset_state got=%0d exp=0", st1); end
    checks++; if (cnt1 !== 8'd0)  begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt1); end
    checks++; if (out2 !== 1'b0 || cnt2 !== 2'd0 || st2 !== 2'd0)
      begin errors++; $display("FAIL reset_dut2 got out=%b st=%0d cnt=%0d exp 0/0/0", out2, st2, cnt2); end
    reset_n = 1'b1; in_v = 4'h0; fault_in = 1'b0;
    checks++; if (dut.w_lfsr !== 16'hACE1)
      begin errors++; $display("FAIL reset_lfsr got=%h exp=ace1", dut.w_lfsr); end
  endtask

  task automatic test_mode_all();
    int exp_st[7] = '{1, 1, 1, 1, 2, 2, 0};
    int exp_o[7]  = '{1, 1, 1, 1, 0, 0, 0};
    mode = 2'b11; fault_in = 1'b1; in_v = 4'hF;
    for (int i = 0; i < 7; i++) begin
      tick();
      in_v = 4'h0;
      checks++;
      if (out1 !== exp_o[i][0] || st1 !== exp_st[i][1:0]) begin
        errors++;
        $display("FAIL mode_all[%0d] got out=%b st=%0d exp out=%0d st=%0d", i, out1, st1, exp_o[i], exp_st[i]);
      end
    end
    checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL mode_all_count got=%0d exp=1", cnt1); end
  endtask

  task automatic test_retrigger_cooldown();
    int exp_st[10] = '{1, 1, 1, 1, 1, 1, 2, 2, 0, 0};
    mode = 2'b10; fault_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_v = (i < 3 || i == 7 || i == 8) ? 4'h1 : 4'h0;
      tick();
      checks++;
      if (out1 !== (i <= 5) || st1 !== exp_st[i][1:0]) begin
        errors++;
        $display("FAIL retrig[%0d] got out=%b st=%0d exp out=%0d st=%0d", i, out1, st1, (i <= 5), exp_st[i]);
      end
    end
    checks++; if (cnt1 !== 8'd2) begin errors++; $display("FAIL retrig_count got=%0d exp=2", cnt1); end
  endtask

  task automatic test_sticky_logic_reset();
    int bad;
    int exp_st[6] = '{1, 1, 1, 2, 2, 0};
    mode = 2'b01; sticky = 1'b1; fault_in = 1'b1; in_v = 4'h3;
    tick();
    in_v = 4'h0;
    checks++; if (out1 !== 1'b1 || cnt1 !== 8'd3)
      begin errors++; $display("FAIL sticky_fire got out=%b cnt=%0d exp 1/3", out1, cnt1); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out1 !== 1'b1 || st1 !== 2'd1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sticky_hold got lowcycles=%0d exp=0", bad); end
    logic_reset = 1'b1; in_v = 4'h3;
    tick();
    checks++; if (out1 !== 1'b0 || st1 !== 2'd0 || cnt1 !== 8'd3)
      begin errors++; $display("FAIL logic_reset got out=%b st=%0d cnt=%0d exp 0/0/3", out1, st1, cnt1); end
    logic_reset = 1'b0; in_v = 4'h0;
    tick();
    checks++; if (st1 !== 2'd0 || out1 !== 1'b0)
      begin errors++; $display("FAIL post_lreset got out=%b st=%0d exp 0/0", out1, st1); end
    // Sticky again, then release: countdown resumes from the frozen hold value.
    in_v = 4'h3;
    tick();
    in_v = 4'h0;
    repeat (5) tick();
    sticky = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out1 !== (i < 3) || st1 !== exp_st[i][1:0]) begin
        errors++;
        $display("FAIL sticky_release[%0d] got out=%b st=%0d exp out=%0d st=%0d", i, out1, st1, (i < 3), exp_st[i]);
      end
    end
    checks++; if (cnt1 !== 8'd4) begin errors++; $display("FAIL sticky_count got=%0d exp=4", cnt1); end
  endtask

  task automatic test_prop_stats();
    int obs, mism, zeros;
    logic prev_e;
    logic [3:0] ones;
    mode = 2'b00; sticky = 1'b0; fault_in = 1'b1; in_v = 4'h3;
    obs = 0; mism = 0; prev_e = 1'b0;
    for (int i = 0; i <= 10000; i++) begin
      if (i > 0) begin
        if (out2 === 1'b1) obs++;
        if (out2 !== prev_e) mism++;
      end
      ones = 4'd2;
      prev_e = (32'(m_lfsr) < 32'(ones) * 32'd16383);
      tick();
    end
    checks++; if (obs < 4700 || obs > 5300)
      begin errors++; $display("FAIL prop_rate got=%0d/10000 exp 4700..5300", obs); end
    checks++; if (mism !== 0)
      begin errors++; $display("FAIL prop_exact got mismatches=%0d exp=0", mism); end
    in_v = 4'h0; zeros = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (out2 !== 1'b0) zeros++; end
    checks++; if (zeros !== 0) begin errors++; $display("FAIL prop_in0 got fires=%0d exp=0", zeros); end
    in_v = 4'h3; fault_in = 1'b0; zeros = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (out2 !== 1'b0) zeros++; end
    checks++; if (zeros !== 0) begin errors++; $display("FAIL prop_fault_off got fires=%0d exp=0", zeros); end
  endtask

  task automatic test_saturation();
    int exp_c[5] = '{1, 2, 3, 3, 3};
    reset_n = 1'b0; in_v = 4'h0; fault_in = 1'b0;
    tick(); tick();
    reset_n = 1'b1; mode = 2'b11; sticky = 1'b0; fault_in = 1'b1;
    for (int f = 0; f < 5; f++) begin
      in_v = 4'hF;
      tick();
      in_v = 4'h0;
      tick();
      checks++;
      if (cnt2 !== exp_c[f][1:0]) begin
        errors++;
        $display("FAIL saturate[%0d] got=%0d exp=%0d", f, cnt2, exp_c[f]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_all();
    test_retrigger_cooldown();
    test_sticky_logic_reset();
    test_prop_stats();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
